fifo_sync_thresh: RTL and testbench
===================================

// Module: fifo_sync_thresh
// PURPOSE
//   Single-clock, parametrised FIFO for DAQ data paths: buffers sensor words between producer and consumer.
//   Successor to the dual-clock FIFO for same-domain links.
//   Adds occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags.
//   Adds a selectable first-word-fall-through (FWFT) read mode.
// PARAMETERS
//   DATA_WIDTH  32  data word width in bits
//   ADDR_WIDTH  4   address bits; DEPTH = 2**ADDR_WIDTH entries
//   FWFT        0   0 = standard registered read, 1 = first-word-fall-through
//   AFULL_TH    12  almost_full asserted when count >= AFULL_TH (legal 1..DEPTH)
//   AEMPTY_TH   2   almost_empty asserted when count <= AEMPTY_TH (legal 0..DEPTH-1)
// PORTS
//   clk           in   1             single clock, rising edge
//   rst           in   1             asynchronous reset, active-high
//   wr_en         in   1             write request
//   din           in   DATA_WIDTH    write data
//   rd_en         in   1             read request (FWFT: pop/acknowledge head word)
//   dout          out  DATA_WIDTH    read data
//   valid         out  1             dout holds a valid word
//   full          out  1             count == DEPTH
//   empty         out  1             count == 0
//   almost_full   out  1             count >= AFULL_TH
//   almost_empty  out  1             count <= AEMPTY_TH
//   count         out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
//   overflow      out  1             sticky: write attempted while full
//   underflow     out  1             sticky: read attempted while empty
//   clr_err       in   1             synchronous clear of overflow/underflow
// BEHAVIOUR
//   - Reset (asynchronous, immediate):
//     - wr_ptr/rd_ptr/count = 0; empty = 1, almost_empty = 1.
//     - full, almost_full, valid, overflow, underflow = 0; dout = 0.
//     - Memory array is not cleared.
//   - Write accepted iff wr_en && !full. Rejected writes never modify memory or pointers.
//   - Read accepted iff rd_en && !empty. A read does not make room for a same-cycle write when full.
//   - Pointers are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0.
//   - count: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
//   - full/empty/almost_* are registered and reflect count after the same edge that updates count.
//   - FWFT=0:
//     - On an accepted read, dout <= mem[rd_ptr] and valid = 1 for exactly the next cycle.
//     - dout holds its last value otherwise; valid = 0 otherwise.
//   - FWFT=1:
//     - valid = !empty; dout = mem[rd_ptr] (head word) whenever valid.
//     - Word written into an empty FIFO at edge N is on dout with valid=1 after edge N.
//     - rd_en with valid=1 pops; the next word (if any) appears after that edge.
//   - overflow set on wr_en && full; underflow set on rd_en && empty. Both stay set until clr_err.
//   - Set wins over a same-cycle clr_err.
//   - Reset mid-stream discards all contents; the first write after reset lands at address 0.
//   - Illegal thresholds are flagged by a simulation-time $error in an initial block.
// TESTING  (DATA_WIDTH=32, ADDR_WIDTH=2, AFULL_TH=3, AEMPTY_TH=1)
//   1. Pulse rst -> count=0, empty=1, almost_empty=1, full=0, valid=0, dout=0, overflow=underflow=0.
//   2. Write 0xAAAA, 0xBBBB, 0xCCCC, 0xDDDD:
//      - count steps 1..4; almost_empty drops at count=2; almost_full at count=3; full at count=4.
//      - Then write 0xEEEE -> rejected, count stays 4, overflow=1.
//   3. FWFT=0, read 4 words:
//      - dout = AAAA, BBBB, CCCC, DDDD, each with a 1-cycle valid pulse the cycle after rd_en.
//      - empty=1 after the 4th read.
//      - Extra rd_en -> valid stays 0, underflow=1, dout holds 0xDDDD.
//   4. At count=2, wr_en+rd_en in the same cycle -> count stays 2, FIFO order preserved.
//      - At count=4 (full), wr_en+rd_en -> read accepted, write rejected, count=3, overflow=1.
//   5. FWFT=1: write 0xAAAA into an empty FIFO -> next cycle valid=1, dout=0xAAAA with no rd_en.
//      - rd_en -> valid=0, empty=1 after the edge.
//   6. At count=3, assert rst between edges:
//      - count=0, empty=1, valid=0 immediately.
//      - After release, write 0x1234 and read it back -> 0x1234.
//      - clr_err pulse clears a previously set overflow.

Source files
------------

// File: rtl/fifo_sync_thresh.sv
// fifo_sync_thresh
//   Single-clock FIFO for sensor data paths. Tracks occupancy and raises
//   almost-full/almost-empty at programmable thresholds. Overflow and
//   underflow flags are sticky. The read side is either a registered read
//   or first-word-fall-through, chosen by FWFT.
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   wr_en, din         write request and data
//   rd_en              read request (FWFT: pop the head word)
//   dout, valid        read data and its qualifier
//   full, empty        occupancy at DEPTH / at zero
//   almost_full        count >= AFULL_TH
//   almost_empty       count <= AEMPTY_TH
//   count              occupancy, 0..DEPTH
//   overflow           sticky: write attempted while full
//   underflow          sticky: read attempted while empty
//   clr_err            synchronous clear of overflow/underflow
module fifo_sync_thresh #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = 0,
    parameter int AFULL_TH   = 12,
    parameter int AEMPTY_TH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH + 1)'(AFULL_TH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH + 1)'(AEMPTY_TH);

    initial begin
        if (AFULL_TH < 1 || AFULL_TH > DEPTH)
            $error("fifo_sync_thresh: AFULL_TH=%0d outside 1..%0d", AFULL_TH, DEPTH);
        if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1)
            $error("fifo_sync_thresh: AEMPTY_TH=%0d outside 0..%0d", AEMPTY_TH, DEPTH - 1);
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic                  wr_ok;
    logic                  rd_ok;

    // Gating uses the registered flags, so a read never frees a slot for a
    // same-cycle write into a full FIFO.
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    always_comb begin
        count_nxt = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok)
                rd_ptr <= rd_ptr + 1'b1;
            count        <= count_nxt;
            full         <= (count_nxt == DEPTH_C);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AFULL_C);
            almost_empty <= (count_nxt <= AEMPTY_C);
        end
    end

    // A new error event takes priority over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full)
                overflow <= 1'b1;
            else if (clr_err)
                overflow <= 1'b0;
            if (rd_en && empty)
                underflow <= 1'b1;
            else if (clr_err)
                underflow <= 1'b0;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented combinationally; forced to zero while
            // empty so uninitialised storage never reaches the output.
            assign valid = !empty;
            assign dout  = empty ? '0 : mem[rd_ptr];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;
            logic                  valid_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_ok;
                    if (rd_ok)
                        dout_q <= mem[rd_ptr];
                end
            end

            assign valid = valid_q;
            assign dout  = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_thresh.sv
module tb_fifo_sync_thresh;

    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic        clr_err = 1'b0;
    logic [31:0] din = '0;

    logic [31:0] s_dout, f_dout;
    logic        s_valid, s_full, s_empty, s_afull, s_aempty, s_ovf, s_unf;
    logic        f_valid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
    logic [2:0]  s_count, f_count;

    int total = 0;
    int bad   = 0;

    // reference model
    logic [31:0] mq[$];
    bit          m_ovf, m_unf, m_v0;
    logic [31:0] m_d0;

    always #5 clk = ~clk;

    fifo_sync_thresh #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .FWFT(0), .AFULL_TH(AF), .AEMPTY_TH(AE)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(s_dout), .valid(s_valid), .full(s_full), .empty(s_empty),
        .almost_full(s_afull), .almost_empty(s_aempty), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf), .clr_err(clr_err));

    fifo_sync_thresh #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .FWFT(1), .AFULL_TH(AF), .AEMPTY_TH(AE)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(f_dout), .valid(f_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_afull), .almost_empty(f_aempty), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf), .clr_err(clr_err));

    task automatic model_clear();
        mq.delete();
        m_ovf = 0;
        m_unf = 0;
        m_v0  = 0;
        m_d0  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; wr_en = 0; rd_en = 0; clr_err = 0;
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock of stimulus; model advances on the edge, outputs sampled 1ns later.
    task automatic step(input bit w, input logic [31:0] d, input bit r, input bit c);
        int pre;
        @(negedge clk);
        wr_en = w; din = d; rd_en = r; clr_err = c;
        @(posedge clk);
        pre = mq.size();
        if (r && pre > 0) begin
            m_d0 = mq.pop_front();
            m_v0 = 1;
        end else begin
            m_v0 = 0;
        end
        if (w && pre < DEPTH) mq.push_back(d);
        if (w && pre == DEPTH) m_ovf = 1; else if (c) m_ovf = 0;
        if (r && pre == 0)     m_unf = 1; else if (c) m_unf = 0;
        #1;
        wr_en = 0; rd_en = 0; clr_err = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (s_count !== 3'd0)   begin bad++; $display("FAIL reset_count got=%0d exp=0", s_count); end
        total++; if (s_empty !== 1'b1)   begin bad++; $display("FAIL reset_empty got=%b exp=1", s_empty); end
        total++; if (s_aempty !== 1'b1)  begin bad++; $display("FAIL reset_aempty got=%b exp=1", s_aempty); end
        total++; if (s_full !== 1'b0)    begin bad++; $display("FAIL reset_full got=%b exp=0", s_full); end
        total++; if (s_afull !== 1'b0)   begin bad++; $display("FAIL reset_afull got=%b exp=0", s_afull); end
        total++; if (s_valid !== 1'b0)   begin bad++; $display("FAIL reset_valid got=%b exp=0", s_valid); end
        total++; if (f_valid !== 1'b0)   begin bad++; $display("FAIL reset_fvalid got=%b exp=0", f_valid); end
        total++; if (s_dout !== 32'h0)   begin bad++; $display("FAIL reset_dout got=%h exp=0", s_dout); end
        total++; if (f_dout !== 32'h0)   begin bad++; $display("FAIL reset_fdout got=%h exp=0", f_dout); end
        total++; if (s_ovf !== 1'b0)     begin bad++; $display("FAIL reset_ovf got=%b exp=0", s_ovf); end
        total++; if (s_unf !== 1'b0)     begin bad++; $display("FAIL reset_unf got=%b exp=0", s_unf); end
    endtask

    task automatic test_fill_overflow();
        logic [31:0] words [4] = '{32'hAAAA, 32'hBBBB, 32'hCCCC, 32'hDDDD};
        for (int i = 0; i < 4; i++) begin
            step(1, words[i], 0, 0);
            total++; if (s_count !== 3'(i + 1)) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, s_count, i + 1); end
            total++; if (s_aempty !== ((i + 1) <= AE)) begin bad++; $display("FAIL fill_aempty[%0d] got=%b", i, s_aempty); end
            total++; if (s_afull !== ((i + 1) >= AF)) begin bad++; $display("FAIL fill_afull[%0d] got=%b", i, s_afull); end
            total++; if (s_full !== ((i + 1) == DEPTH)) begin bad++; $display("FAIL fill_full[%0d] got=%b", i, s_full); end
        end
        step(1, 32'hEEEE, 0, 0);
        total++; if (s_count !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", s_count); end
        total++; if (s_ovf !== 1'b1)   begin bad++; $display("FAIL ovf_flag got=%b exp=1", s_ovf); end
    endtask

    task automatic test_read_std();
        logic [31:0] words [4] = '{32'hAAAA, 32'hBBBB, 32'hCCCC, 32'hDDDD};
        for (int i = 0; i < 4; i++) begin
            step(0, '0, 1, 0);
            total++; if (s_valid !== 1'b1) begin bad++; $display("FAIL rd_valid[%0d] got=%b exp=1", i, s_valid); end
            total++; if (s_dout !== words[i]) begin bad++; $display("FAIL rd_dout[%0d] got=%h exp=%h", i, s_dout, words[i]); end
            step(0, '0, 0, 0);
            total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL rd_pulse[%0d] got=%b exp=0", i, s_valid); end
            total++; if (s_dout !== words[i]) begin bad++; $display("FAIL rd_hold[%0d] got=%h exp=%h", i, s_dout, words[i]); end
        end
        total++; if (s_empty !== 1'b1) begin bad++; $display("FAIL rd_empty got=%b exp=1", s_empty); end
        step(0, '0, 1, 0);
        total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL unf_valid got=%b exp=0", s_valid); end
        total++; if (s_unf !== 1'b1) begin bad++; $display("FAIL unf_flag got=%b exp=1", s_unf); end
        total++; if (s_dout !== 32'hDDDD) begin bad++; $display("FAIL unf_dout got=%h exp=dddd", s_dout); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] exp_rd [3] = '{32'h52, 32'h53, 32'h54};
        step(0, '0, 0, 1);
        total++; if (s_ovf !== 1'b0 || s_unf !== 1'b0) begin bad++; $display("FAIL clr_both got=%b%b exp=00", s_ovf, s_unf); end
        step(1, 32'h11, 0, 0);
        step(1, 32'h22, 0, 0);
        step(1, 32'h33, 1, 0);
        total++; if (s_count !== 3'd2) begin bad++; $display("FAIL sim_count got=%0d exp=2", s_count); end
        total++; if (s_dout !== 32'h11) begin bad++; $display("FAIL sim_dout0 got=%h exp=11", s_dout); end
        step(0, '0, 1, 0);
        total++; if (s_dout !== 32'h22) begin bad++; $display("FAIL sim_dout1 got=%h exp=22", s_dout); end
        step(0, '0, 1, 0);
        total++; if (s_dout !== 32'h33) begin bad++; $display("FAIL sim_dout2 got=%h exp=33", s_dout); end
        for (int i = 0; i < 4; i++) step(1, 32'h51 + i, 0, 0);
        total++; if (s_full !== 1'b1) begin bad++; $display("FAIL sim_full got=%b exp=1", s_full); end
        step(1, 32'h99, 1, 0);
        total++; if (s_count !== 3'd3) begin bad++; $display("FAIL simfull_count got=%0d exp=3", s_count); end
        total++; if (s_ovf !== 1'b1) begin bad++; $display("FAIL simfull_ovf got=%b exp=1", s_ovf); end
        total++; if (s_dout !== 32'h51) begin bad++; $display("FAIL simfull_dout got=%h exp=51", s_dout); end
        for (int i = 0; i < 3; i++) begin
            step(0, '0, 1, 0);
            total++; if (s_dout !== exp_rd[i]) begin bad++; $display("FAIL simfull_drain[%0d] got=%h exp=%h", i, s_dout, exp_rd[i]); end
        end
        total++; if (s_empty !== 1'b1) begin bad++; $display("FAIL simfull_empty got=%b exp=1", s_empty); end
    endtask

    task automatic test_fwft();
        do_reset();
        step(1, 32'hAAAA, 0, 0);
        total++; if (f_valid !== 1'b1) begin bad++; $display("FAIL fwft_valid got=%b exp=1", f_valid); end
        total++; if (f_dout !== 32'hAAAA) begin bad++; $display("FAIL fwft_dout got=%h exp=aaaa", f_dout); end
        step(0, '0, 1, 0);
        total++; if (f_valid !== 1'b0) begin bad++; $display("FAIL fwft_pop_valid got=%b exp=0", f_valid); end
        total++; if (f_empty !== 1'b1) begin bad++; $display("FAIL fwft_pop_empty got=%b exp=1", f_empty); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) step(1, 32'h70 + i, 0, 0);
        step(0, '0, 1, 0);
        step(1, 32'h73, 0, 0);
        total++; if (s_count !== 3'd3) begin bad++; $display("FAIL arst_pre_count got=%0d exp=3", s_count); end
        @(negedge clk);
        #2 rst = 1'b1;
        model_clear();
        #1;
        total++; if (s_count !== 3'd0) begin bad++; $display("FAIL arst_count got=%0d exp=0", s_count); end
        total++; if (s_empty !== 1'b1) begin bad++; $display("FAIL arst_empty got=%b exp=1", s_empty); end
        total++; if (s_valid !== 1'b0 || f_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b%b exp=00", s_valid, f_valid); end
        @(negedge clk);
        rst = 1'b0;
        step(1, 32'h1234, 0, 0);
        total++; if (f_dout !== 32'h1234) begin bad++; $display("FAIL arst_fdout got=%h exp=1234", f_dout); end
        step(0, '0, 1, 0);
        total++; if (s_dout !== 32'h1234) begin bad++; $display("FAIL arst_dout got=%h exp=1234", s_dout); end
        for (int i = 0; i < 4; i++) step(1, 32'h80 + i, 0, 0);
        step(1, 32'h90, 0, 1);
        total++; if (s_ovf !== 1'b1) begin bad++; $display("FAIL set_wins got=%b exp=1", s_ovf); end
        step(0, '0, 0, 1);
        total++; if (s_ovf !== 1'b0) begin bad++; $display("FAIL clr_ovf got=%b exp=0", s_ovf); end
    endtask

    task automatic test_random();
        bit w, r, c;
        int wbias;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            wbias = ((n / 60) % 2 == 0) ? 70 : 30;
            w = ($urandom_range(0, 99) < wbias);
            r = ($urandom_range(0, 99) < (100 - wbias));
            c = ($urandom_range(0, 24) == 0);
            step(w, $urandom, r, c);
            total++; if (s_count !== 3'(mq.size())) begin bad++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", n, s_count, mq.size()); end
            total++; if (s_full !== (mq.size() == DEPTH)) begin bad++; $display("FAIL rnd_full[%0d] got=%b", n, s_full); end
            total++; if (s_empty !== (mq.size() == 0)) begin bad++; $display("FAIL rnd_empty[%0d] got=%b", n, s_empty); end
            total++; if (s_afull !== (mq.size() >= AF)) begin bad++; $display("FAIL rnd_afull[%0d] got=%b", n, s_afull); end
            total++; if (s_aempty !== (mq.size() <= AE)) begin bad++; $display("FAIL rnd_aempty[%0d] got=%b", n, s_aempty); end
            total++; if (s_ovf !== m_ovf || f_ovf !== m_ovf) begin bad++; $display("FAIL rnd_ovf[%0d] got=%b%b exp=%b", n, s_ovf, f_ovf, m_ovf); end
            total++; if (s_unf !== m_unf || f_unf !== m_unf) begin bad++; $display("FAIL rnd_unf[%0d] got=%b%b exp=%b", n, s_unf, f_unf, m_unf); end
            total++; if (s_valid !== m_v0) begin bad++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", n, s_valid, m_v0); end
            total++; if (s_dout !== m_d0) begin bad++; $display("FAIL rnd_dout[%0d] got=%h exp=%h", n, s_dout, m_d0); end
            total++; if (f_valid !== (mq.size() > 0)) begin bad++; $display("FAIL rnd_fvalid[%0d] got=%b", n, f_valid); end
            if (mq.size() > 0) begin
                total++; if (f_dout !== mq[0]) begin bad++; $display("FAIL rnd_fdout[%0d] got=%h exp=%h", n, f_dout, mq[0]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_read_std();
        test_simultaneous();
        test_fwft();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
